// File: rtl/cvxif_add_sequencer_if.sv
// Issue / commit / result bundle for cvxif_add_sequencer.
// The slave modport is the sequencer side; the master modport is the core side.
interface cvxif_add_sequencer_if #(
    parameter int DEPTH    = 4,
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic [4:0]          issue_rd_i;
    logic                issue_we_i;
    logic [XLEN-1:0]     issue_rs1_i;
    logic [XLEN-1:0]     issue_rs2_i;

    logic                commit_valid_i;
    logic [ID_WIDTH-1:0] commit_id_i;
    logic                commit_kill_i;

    logic                result_valid_o;
    logic                result_ready_i;
    logic [ID_WIDTH-1:0] result_id_o;
    logic [4:0]          result_rd_o;
    logic                result_we_o;
    logic [XLEN-1:0]     result_data_o;

    logic [CNT_W-1:0]    count_o;
    logic                busy_o;

    modport slave (
        input  issue_valid_i, issue_id_i, issue_rd_i, issue_we_i, issue_rs1_i, issue_rs2_i,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        input  result_ready_i,
        output issue_ready_o,
        output result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o,
        output count_o, busy_o
    );

    modport master (
        output issue_valid_i, issue_id_i, issue_rd_i, issue_we_i, issue_rs1_i, issue_rs2_i,
        output commit_valid_i, commit_id_i, commit_kill_i,
        output result_ready_i,
        input  issue_ready_o,
        input  result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o,
        input  count_o, busy_o
    );
endinterface

// File: rtl/cvxif_add_sequencer.sv
// In-order add sequencer: issued adds wait in a circular table until committed, then retire in order.
// Macro CVXIF_ADD_SEQ_KILL_EN enables killed commits (dropped silently at the head).
module cvxif_add_sequencer #(
    parameter int DEPTH    = 4,
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 4
) (
    input logic                   clk_i,
    input logic                   rst_i,
    cvxif_add_sequencer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH-1:0]    committed_q, committed_d;
    logic [DEPTH-1:0]    killed_q, killed_d;
    logic [ID_WIDTH-1:0] id_q [DEPTH];
    logic [ID_WIDTH-1:0] id_d [DEPTH];
    logic [4:0]          rd_q [DEPTH];
    logic [4:0]          rd_d [DEPTH];
    logic                we_q [DEPTH];
    logic                we_d [DEPTH];
    logic [XLEN-1:0]     data_q [DEPTH];
    logic [XLEN-1:0]     data_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic kill_req;
`ifdef CVXIF_ADD_SEQ_KILL_EN
    assign kill_req = bus.commit_kill_i;
`else
    logic unused_commit_kill;
    assign kill_req           = 1'b0;
    assign unused_commit_kill = bus.commit_kill_i;
`endif

    logic dup_id, issue_ready, push, head_done, result_valid, pop, same_cycle_commit;

    always_comb begin
        dup_id = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && id_q[i] == bus.issue_id_i) dup_id = 1'b1;
        end
    end

    assign issue_ready  = (count_q < DEPTH_C) && !dup_id;
    assign push         = bus.issue_valid_i && issue_ready;
    assign head_done    = valid_q[head_q] && committed_q[head_q];
    assign result_valid = head_done && !killed_q[head_q];
    assign pop          = head_done && (killed_q[head_q] || bus.result_ready_i);
    assign same_cycle_commit = bus.commit_valid_i && (bus.commit_id_i == bus.issue_id_i);

    always_comb begin
        valid_d     = valid_q;
        committed_d = committed_q;
        killed_d    = killed_q;
        id_d        = id_q;
        rd_d        = rd_q;
        we_d        = we_q;
        data_d      = data_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

        // Ids are unique among valid entries, so at most one entry can match a commit.
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.commit_valid_i && valid_q[i] && !committed_q[i] && id_q[i] == bus.commit_id_i) begin
                committed_d[i] = 1'b1;
                killed_d[i]    = kill_req;
            end
        end

        if (pop) begin
            valid_d[head_q]     = 1'b0;
            committed_d[head_q] = 1'b0;
            killed_d[head_q]    = 1'b0;
            head_d              = head_q + PTR_W'(1);
        end

        if (push) begin
            valid_d[tail_q]     = 1'b1;
            committed_d[tail_q] = same_cycle_commit;
            killed_d[tail_q]    = same_cycle_commit && kill_req;
            id_d[tail_q]        = bus.issue_id_i;
            rd_d[tail_q]        = bus.issue_rd_i;
            we_d[tail_q]        = bus.issue_we_i;
            data_d[tail_q]      = bus.issue_rs1_i + bus.issue_rs2_i;
            tail_d              = tail_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            committed_q <= committed_d;
            killed_q    <= killed_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
        id_q   <= id_d;
        rd_q   <= rd_d;
        we_q   <= we_d;
        data_q <= data_d;
    end

    assign bus.issue_ready_o  = issue_ready;
    assign bus.result_valid_o = result_valid;
    assign bus.result_id_o    = result_valid ? id_q[head_q]   : '0;
    assign bus.result_rd_o    = result_valid ? rd_q[head_q]   : '0;
    assign bus.result_we_o    = result_valid ? we_q[head_q]   : 1'b0;
    assign bus.result_data_o  = result_valid ? data_q[head_q] : '0;
    assign bus.count_o        = count_q;
    assign bus.busy_o         = (count_q != '0);
endmodule

// File: tb/tb_cvxif_add_sequencer.sv
// Self-checking bench for cvxif_add_sequencer: hand vectors, corner sequences, random traffic vs a queue model.
module tb_cvxif_add_sequencer;
    localparam int DEPTH    = 4;
    localparam int XLEN     = 32;
    localparam int ID_WIDTH = 4;
`ifdef CVXIF_ADD_SEQ_KILL_EN
    localparam bit KILL_EN = 1'b1;
`else
    localparam bit KILL_EN = 1'b0;
`endif

    typedef struct {
        logic iv; logic [3:0] iid; logic [4:0] rd; logic we; logic [31:0] rs1; logic [31:0] rs2;
        logic cv; logic [3:0] cid; logic ck; logic rr; logic rst;
    } stim_t;
    typedef struct {
        logic ir; logic rv; logic [3:0] rid; logic [4:0] rrd; logic rwe; logic [31:0] rdata; logic [2:0] cnt;
    } exp_t;
    typedef struct { stim_t s; exp_t e; } vec_t;
    typedef struct { logic [3:0] id; logic [4:0] rd; logic we; logic [31:0] data; bit committed; bit killed; } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    entry_t     mq[$];
    logic [3:0] got_ids[$];

    always #5 clk = ~clk;

    cvxif_add_sequencer_if #(.DEPTH(DEPTH), .XLEN(XLEN), .ID_WIDTH(ID_WIDTH)) bus ();

    cvxif_add_sequencer #(.DEPTH(DEPTH), .XLEN(XLEN), .ID_WIDTH(ID_WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic stim_t mk(logic iv, logic [3:0] iid, logic [4:0] rd, logic we, logic [31:0] rs1,
                                 logic [31:0] rs2, logic cv, logic [3:0] cid, logic ck, logic rr);
        stim_t s;
        s.iv = iv; s.iid = iid; s.rd = rd; s.we = we; s.rs1 = rs1; s.rs2 = rs2;
        s.cv = cv; s.cid = cid; s.ck = ck; s.rr = rr; s.rst = 1'b0;
        return s;
    endfunction

    function automatic exp_t mke(logic ir, logic rv, logic [3:0] rid, logic [4:0] rrd, logic rwe,
                                 logic [31:0] rdata, logic [2:0] cnt);
        exp_t e;
        e.ir = ir; e.rv = rv; e.rid = rid; e.rrd = rrd; e.rwe = rwe; e.rdata = rdata; e.cnt = cnt;
        return e;
    endfunction

    // Reference model: a plain in-order queue of pending adds.
    function automatic exp_t model_expect(stim_t s);
        exp_t e;
        e = mke(1'b0, 1'b0, '0, '0, 1'b0, '0, 3'(mq.size()));
        e.ir = (mq.size() < DEPTH);
        foreach (mq[i]) if (mq[i].id == s.iid) e.ir = 1'b0;
        if (mq.size() > 0 && mq[0].committed && !mq[0].killed) begin
            e.rv = 1'b1; e.rid = mq[0].id; e.rrd = mq[0].rd; e.rwe = mq[0].we; e.rdata = mq[0].data;
        end
        return e;
    endfunction

    task automatic model_step(stim_t s);
        exp_t   e;
        bit     do_pop;
        entry_t n;
        if (s.rst) begin
            mq.delete();
            return;
        end
        e = model_expect(s);
        do_pop = mq.size() > 0 && mq[0].committed && (mq[0].killed || s.rr);
        if (s.cv) begin
            foreach (mq[i]) begin
                if (mq[i].id == s.cid && !mq[i].committed) begin
                    mq[i].committed = 1'b1;
                    mq[i].killed    = KILL_EN && s.ck;
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (s.iv && e.ir) begin
            n.id = s.iid; n.rd = s.rd; n.we = s.we; n.data = s.rs1 + s.rs2;
            n.committed = s.cv && (s.cid == s.iid);
            n.killed    = n.committed && KILL_EN && s.ck;
            mq.push_back(n);
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(stim_t s);
        rst                = s.rst;
        bus.issue_valid_i  = s.iv;
        bus.issue_id_i     = s.iid;
        bus.issue_rd_i     = s.rd;
        bus.issue_we_i     = s.we;
        bus.issue_rs1_i    = s.rs1;
        bus.issue_rs2_i    = s.rs2;
        bus.commit_valid_i = s.cv;
        bus.commit_id_i    = s.cid;
        bus.commit_kill_i  = s.ck;
        bus.result_ready_i = s.rr;
    endtask

    task automatic checkOutput(exp_t e);
        check("issue_ready", 32'(bus.issue_ready_o), 32'(e.ir));
        check("result_valid", 32'(bus.result_valid_o), 32'(e.rv));
        check("result_id", 32'(bus.result_id_o), 32'(e.rid));
        check("result_rd", 32'(bus.result_rd_o), 32'(e.rrd));
        check("result_we", 32'(bus.result_we_o), 32'(e.rwe));
        check("result_data", bus.result_data_o, e.rdata);
        check("count", 32'(bus.count_o), 32'(e.cnt));
        check("busy", 32'(bus.busy_o), 32'(e.cnt != 3'd0));
    endtask

    // One clock: drive, compare at the falling edge, advance the model at the rising edge.
    task automatic run_cycle(stim_t s, bit use_tab, exp_t te);
        exp_t e;
        applyStimulus(s);
        @(negedge clk);
        e = use_tab ? te : model_expect(s);
        checkOutput(e);
        if (bus.result_valid_o && s.rr) got_ids.push_back(bus.result_id_o);
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic step(stim_t s);
        exp_t dummy;
        dummy = mke(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        run_cycle(s, 1'b0, dummy);
    endtask

    stim_t idle;
    vec_t  vecs[15];

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1),                   mke(1, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{mk(1, 3, 10, 1, 5, 7, 1, 3, 0, 1),                  mke(1, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1),                   mke(1, 1, 3, 10, 1, 12, 1)};
        vecs[3]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1),                   mke(1, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{mk(1, 5, 1, 0, 32'hFFFF_FFFF, 2, 0, 0, 0, 1),      mke(1, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{mk(0, 5, 0, 0, 0, 0, 1, 5, 0, 1),                   mke(0, 0, 0, 0, 0, 0, 1)};
        vecs[6]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),                   mke(1, 1, 5, 1, 0, 1, 1)};
        vecs[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1),                   mke(1, 1, 5, 1, 0, 1, 1)};
        vecs[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1),                   mke(1, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 1),                   mke(1, 0, 0, 0, 0, 0, 0)};
        vecs[10] = '{mk(1, 0, 31, 1, 32'h8000_0000, 32'h8000_0000, 1, 7, 0, 1), mke(1, 0, 0, 0, 0, 0, 0)};
        vecs[11] = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1),                   mke(1, 0, 0, 0, 0, 0, 1)};
        vecs[12] = '{mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 1),                   mke(1, 0, 0, 0, 0, 0, 1)};
        vecs[13] = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1),                   mke(1, 1, 0, 31, 1, 0, 1)};
        vecs[14] = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1),                   mke(1, 0, 0, 0, 0, 0, 0)};

        begin
            stim_t r;
            r = idle; r.rst = 1'b1;
            applyStimulus(r);
            repeat (2) @(posedge clk);
            #1;
            mq.delete();
        end

        for (int i = 0; i < 15; i++) run_cycle(vecs[i].s, 1'b1, vecs[i].e);

        // Full table, out-of-order commits, in-order retirement.
        got_ids.delete();
        for (int i = 0; i < 4; i++) step(mk(1, 4'(i), 5'(i), 1, 32'(i), 10, 0, 0, 0, 1));
        applyStimulus(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 1));
        #1;
        check("full_issue_ready", 32'(bus.issue_ready_o), 0);
        check("full_count", 32'(bus.count_o), 4);
        step(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 1));
        step(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 1));
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        step(idle);
        step(idle);
        step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        for (int i = 0; i < 10 && got_ids.size() < 3; i++) step(idle);
        check("order_len", 32'(got_ids.size()), 3);
        for (int i = 0; i < 3 && i < got_ids.size(); i++) check("order_id", 32'(got_ids[i]), 32'(i));
        check("left_count", 32'(bus.count_o), 1);
        step(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 1));
        for (int i = 0; i < 10 && bus.count_o != 0; i++) step(idle);
        check("drain_count", 32'(bus.count_o), 0);

        // Back-pressure: payload holds while ready is low; duplicate id stalls issue.
        step(mk(1, 9, 4, 1, 100, 23, 1, 9, 0, 0));
        for (int i = 0; i < 3; i++) begin
            step(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0));
            check("hold_valid", 32'(bus.result_valid_o), 1);
            check("hold_data", bus.result_data_o, 123);
            check("hold_id", 32'(bus.result_id_o), 9);
            check("dup_issue_ready", 32'(bus.issue_ready_o), 0);
        end
        step(idle);
        step(idle);

        // Reset with work pending; issue/commit in the reset cycle are ignored.
        for (int i = 0; i < 3; i++) step(mk(1, 4'(i + 1), 0, 1, 32'(i), 1, 0, 0, 0, 1));
        begin
            stim_t r;
            r = mk(1, 7, 0, 1, 1, 1, 1, 1, 0, 1);
            r.rst = 1'b1;
            step(r);
        end
        check("reset_count", 32'(bus.count_o), 0);
        check("reset_result_valid", 32'(bus.result_valid_o), 0);
        got_ids.delete();
        for (int i = 0; i < 4; i++) step(mk(0, 0, 0, 0, 0, 0, 1, 4'(i + 1), 0, 1));
        check("no_stale_result", 32'(got_ids.size()), 0);

`ifdef CVXIF_ADD_SEQ_KILL_EN
        // A killed head retires silently, delaying the next result by one cycle.
        step(mk(1, 1, 2, 1, 1, 1, 0, 0, 0, 1));
        step(mk(1, 2, 3, 1, 2, 2, 0, 0, 0, 1));
        got_ids.delete();
        begin
            int seen_at;
            seen_at = -1;
            for (int i = 0; i < 6; i++) begin
                if (i == 0) step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
                else if (i == 1) step(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 1));
                else step(idle);
                if (got_ids.size() > 0 && seen_at < 0) seen_at = i;
            end
            check("kill_result_count", 32'(got_ids.size()), 1);
            if (got_ids.size() > 0) check("kill_result_id", 32'(got_ids[0]), 2);
            check("kill_result_cycle", 32'(seen_at), 2);
        end
`endif

        // Random traffic against the queue model.
        for (int n = 0; n < 2000; n++) begin
            stim_t s;
            s = mk($urandom_range(0, 9) < 6, 4'($urandom_range(0, 7)), 5'($urandom), 1'($urandom),
                   $urandom, $urandom, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
            s.rst = ($urandom_range(0, 199) == 0);
            step(s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/cvxif_add_sequencer.md
CVXIF_ADD_SEQUENCER -- requirements
Module: cvxif_add_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, which sets the number of in-flight entries (power of two, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, which sets the operand and result width.
REQ-003 SHALL have parameter ID_WIDTH, default 4, which sets the width of the instruction id.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port issue_valid_i, input, 1 bit: the offered instruction is accepted by the decoder.
REQ-007 SHALL have port issue_ready_o, output, 1 bit: the sequencer can take the issue this cycle.
REQ-008 SHALL have ports issue_id_i [ID_WIDTH], issue_rd_i [5], issue_we_i [1], issue_rs1_i [XLEN], issue_rs2_i [XLEN], all inputs: the issue payload.
REQ-009 SHALL have ports commit_valid_i [1], commit_id_i [ID_WIDTH], commit_kill_i [1], all inputs: the commit notification.
REQ-010 SHALL have port result_valid_o, output, 1 bit: the head result is offered.
REQ-011 SHALL have port result_ready_i, input, 1 bit: the core accepts the result.
REQ-012 SHALL have ports result_id_o [ID_WIDTH], result_rd_o [5], result_we_o [1], result_data_o [XLEN], all outputs: the result payload.
REQ-013 SHALL have port count_o, output, clog2(DEPTH)+1 bits: number of occupied entries.
REQ-014 SHALL have port busy_o, output, 1 bit: count_o != 0.

Function
REQ-015 SHALL hold a circular in-order table of DEPTH entries {valid, committed, killed, id, rd, we, data}, with head and tail pointers wrapping modulo DEPTH.
REQ-016 SHALL assert issue_ready_o = (count < DEPTH) AND no valid entry holds issue_id_i (duplicate in-flight id stalls).
REQ-017 SHALL, on issue_valid_i && issue_ready_o, write the tail entry with data = (rs1 + rs2) mod 2^XLEN (carry discarded), committed=0, killed=0, and advance the tail.
REQ-018 SHALL, on commit_valid_i, set committed=1 on the valid, uncommitted entry whose id equals commit_id_i, and also set killed=commit_kill_i on that entry.
REQ-019 SHALL apply a commit whose id equals the entry being issued in the same cycle to that new entry.
REQ-020 SHALL ignore a commit whose id matches no valid, uncommitted entry, and SHALL ignore a second commit to an already-committed entry.
REQ-021 SHALL drive result_valid_o = head.valid && head.committed && !head.killed, with result_* taken from the head entry; all result_* SHALL be 0 when result_valid_o is low.
REQ-022 SHALL pop the head on result_valid_o && result_ready_i.
REQ-023 SHALL pop a committed-and-killed head in one cycle without asserting result_valid_o.
REQ-024 SHALL hold result_valid_o and the payload stable while result_valid_o && !result_ready_i.
REQ-025 SHALL give latency: issue and commit in cycle N gives result_valid_o at N+1 at the earliest.
REQ-026 SHALL return results strictly in issue order; a committed younger entry waits behind an uncommitted head.
REQ-027 SHALL support a push and a pop in the same cycle, leaving count unchanged; when full, issue_ready_o is low even if a pop occurs that cycle.
REQ-028 SHALL hold all outputs at their reset value when issue_valid_i is low and the table is empty.

Reset
REQ-029 SHALL, while rst_i is high at a clock edge, clear all valid/committed/killed bits and set head=tail=0.
REQ-030 SHALL reset outputs to: issue_ready_o=1 (after first edge), result_valid_o=0, result_* = 0, count_o=0, busy_o=0.
REQ-031 SHALL, on reset mid-operation, discard all entries with no result emitted; issue and commit inputs in the reset cycle are ignored.

Configuration
REQ-032 SHALL honour macro CVXIF_ADD_SEQ_KILL_EN: when defined, commit_kill_i behaves per REQ-018/REQ-023.
REQ-033 SHALL, when CVXIF_ADD_SEQ_KILL_EN is undefined, ignore commit_kill_i (every commit is a non-kill commit), so that killed is constant 0 and no entry is ever dropped.

Verification
REQ-034 SHALL pass: issue id=3, rs1=5, rs2=7, rd=10, we=1, with commit id=3 in the same cycle -> next cycle result_valid_o=1, data=12, rd=10, id=3; with ready=1 the entry pops and count_o returns to 0.
REQ-035 SHALL pass: issue rs1=0xFFFFFFFF, rs2=2, committed -> data=0x00000001.
REQ-036 SHALL pass: fill 4 entries (ids 0..3), no commits -> issue_ready_o=0, count_o=4; then commit id 2, then id 0 -> results appear as id 0 only, and id 2 waits until id 1 commits, giving order 0,1,2.
REQ-037 SHALL pass: with KILL_EN defined, issue ids 1 and 2, commit id 1 with kill=1, commit id 2 -> only id 2 result is seen, one cycle later than without the kill.
REQ-038 SHALL pass: hold result_ready_i=0 for 3 cycles with a valid head -> payload unchanged; an issue with a duplicate in-flight id -> issue_ready_o=0.
REQ-039 SHALL pass: assert rst_i with 3 entries pending -> next cycle count_o=0, result_valid_o=0, and no stale result after release.
